// File: rtl/uart_cmd_parser_pkg.sv
// Shared constants and FSM encoding for the UART command-frame parser.
package uart_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_CSUM,
        ST_EXEC,
        ST_RESP0,
        ST_RESP1
    } parser_state_t;

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Bundle of the uart RX/TX FIFO handshakes and the simple register bus.
interface uart_cmd_parser_if;

    logic       rx_available;
    logic [7:0] rx_data;
    logic       rx_data_ack;
    logic       tx_free;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic [7:0] reg_addr;
    logic [7:0] reg_wr_data;
    logic       reg_wr_en;
    logic       reg_rd_en;
    logic [7:0] reg_rd_data;

    modport master (
        input  rx_available, rx_data, tx_free, reg_rd_data,
        output rx_data_ack, tx_data, tx_data_valid,
        output reg_addr, reg_wr_data, reg_wr_en, reg_rd_en
    );

    modport slave (
        output rx_available, rx_data, tx_free, reg_rd_data,
        input  rx_data_ack, tx_data, tx_data_valid,
        input  reg_addr, reg_wr_data, reg_wr_en, reg_rd_en
    );

endinterface

// File: rtl/uart_cmd_parser_byte_reader.sv
// Pops bytes from the uart RX FIFO, leaving a gap cycle after each pop so the
// FIFO's lagging data register has caught up before the next byte is taken.
module uart_byte_reader (
    input  logic       clk_main,
    input  logic       reset,
    input  logic       enable_i,
    input  logic       rx_available_i,
    input  logic [7:0] rx_data_i,
    output logic       rx_data_ack_o,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o
);

    logic gap_q;
    logic ack_d;

    assign ack_d = enable_i && rx_available_i && !gap_q && !reset;

    always_ff @(posedge clk_main) begin
        if (reset) begin
            gap_q <= 1'b0;
        end else begin
            gap_q <= ack_d;
        end
    end

    assign rx_data_ack_o = ack_d;
    assign byte_valid_o  = ack_d;
    assign byte_data_o   = rx_data_i;

endmodule

// File: rtl/uart_cmd_parser.sv
// Framed register read/write command parser between the uart RX and TX FIFOs.
// Frames: A5, CMD, ADDR, [DATA], CSUM; replies ACK (+read data) or NAK.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 120000
) (
    input  logic              clk_main,
    input  logic              reset,
    uart_cmd_parser_if.master bus,
    output logic              busy,
    output logic              frame_err
);

    localparam logic [19:0] TMO_LAST = 20'(TIMEOUT_CYCLES - 1);

    parser_state_t state_q;
    logic [7:0]    cmd_q, addr_q, data_q, csum_q, rd_data_q, tx_data_q;
    logic          good_q, wr_en_q, rd_en_q, frame_err_q, tx_pend_q;
    logic [19:0]   tmo_cnt_q;

    logic          rx_en, in_frame, byte_valid;
    logic [7:0]    byte_data;

    assign in_frame = state_q inside {ST_CMD, ST_ADDR, ST_DATA, ST_CSUM};
    assign rx_en    = in_frame || (state_q == ST_SYNC);

    uart_byte_reader u_reader (
        .clk_main       (clk_main),
        .reset          (reset),
        .enable_i       (rx_en),
        .rx_available_i (bus.rx_available),
        .rx_data_i      (bus.rx_data),
        .rx_data_ack_o  (bus.rx_data_ack),
        .byte_valid_o   (byte_valid),
        .byte_data_o    (byte_data)
    );

    always_ff @(posedge clk_main) begin
        if (reset) begin
            state_q     <= ST_SYNC;
            cmd_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            csum_q      <= '0;
            rd_data_q   <= '0;
            tx_data_q   <= '0;
            good_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            frame_err_q <= 1'b0;
            tx_pend_q   <= 1'b0;
            tmo_cnt_q   <= '0;
        end else begin
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            frame_err_q <= 1'b0;
            tmo_cnt_q   <= (in_frame && !byte_valid) ? tmo_cnt_q + 20'd1 : '0;

            // A stalled frame is abandoned silently: error pulse, no reply, no bus access.
            if (in_frame && !byte_valid && tmo_cnt_q == TMO_LAST) begin
                frame_err_q <= 1'b1;
                tmo_cnt_q   <= '0;
                state_q     <= ST_SYNC;
            end else begin
                case (state_q)
                    ST_SYNC: begin
                        if (byte_valid && byte_data == SYNC_BYTE) begin
                            state_q <= ST_CMD;
                        end
                    end
                    ST_CMD: begin
                        if (byte_valid) begin
                            cmd_q   <= byte_data;
                            csum_q  <= byte_data;
                            state_q <= ST_ADDR;
                        end
                    end
                    ST_ADDR: begin
                        if (byte_valid) begin
                            addr_q  <= byte_data;
                            csum_q  <= csum_q ^ byte_data;
                            state_q <= (cmd_q == CMD_WRITE) ? ST_DATA : ST_CSUM;
                        end
                    end
                    ST_DATA: begin
                        if (byte_valid) begin
                            data_q  <= byte_data;
                            csum_q  <= csum_q ^ byte_data;
                            state_q <= ST_CSUM;
                        end
                    end
                    ST_CSUM: begin
                        if (byte_valid) begin
                            state_q <= ST_EXEC;
                            if ((cmd_q == CMD_WRITE || cmd_q == CMD_READ) && byte_data == csum_q) begin
                                good_q  <= 1'b1;
                                wr_en_q <= (cmd_q == CMD_WRITE);
                                rd_en_q <= (cmd_q == CMD_READ);
                            end else begin
                                good_q      <= 1'b0;
                                frame_err_q <= 1'b1;
                            end
                        end
                    end
                    // Reads linger one extra cycle so reg_rd_data is captured when valid.
                    ST_EXEC: begin
                        if (!rd_en_q) begin
                            if (good_q && cmd_q == CMD_READ) begin
                                rd_data_q <= bus.reg_rd_data;
                            end
                            tx_data_q <= good_q ? ACK_BYTE : NAK_BYTE;
                            state_q   <= ST_RESP0;
                        end
                    end
                    ST_RESP0, ST_RESP1: begin
                        if (!tx_pend_q) begin
                            tx_pend_q <= 1'b1;
                        end else if (bus.tx_free) begin
                            tx_pend_q <= 1'b0;
                            if (state_q == ST_RESP0 && good_q && cmd_q == CMD_READ) begin
                                tx_data_q <= rd_data_q;
                                state_q   <= ST_RESP1;
                            end else begin
                                state_q <= ST_SYNC;
                            end
                        end
                    end
                    default: state_q <= ST_SYNC;
                endcase
            end
        end
    end

    assign bus.reg_addr      = addr_q;
    assign bus.reg_wr_data   = data_q;
    assign bus.reg_wr_en     = wr_en_q;
    assign bus.reg_rd_en     = rd_en_q;
    assign bus.tx_data       = tx_data_q;
    assign bus.tx_data_valid = tx_pend_q && bus.tx_free;
    assign busy              = (state_q != ST_SYNC);
    assign frame_err         = frame_err_q;

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Command-frame parser placed directly downstream of the `uart` block's receive FIFO and upstream of its transmit FIFO. It pops received bytes and assembles framed register read/write commands, verifying an XOR checksum. It drives a simple register bus and pushes ACK/NAK and read-data bytes back into the `uart` transmit path. This gives the host PC register-level access to the FPGA over the serial link.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 120000: inter-byte timeout in `clk_main` cycles (10 ms at 12 MHz); 20-bit counter.

Ports:
- `clk_main` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `rx_available` in 1: uart RX FIFO non-empty.
- `rx_data` in 8: oldest unacknowledged RX byte.
- `rx_data_ack` out 1: one-cycle pop of `rx_data`.
- `tx_free` in 1: uart TX FIFO has space.
- `tx_data` out 8: byte to transmit.
- `tx_data_valid` out 1: one-cycle push of `tx_data`.
- `reg_addr` out 8: register address.
- `reg_wr_data` out 8: register write data.
- `reg_wr_en` out 1: one-cycle write strobe.
- `reg_rd_en` out 1: one-cycle read strobe.
- `reg_rd_data` in 8: read data, valid exactly 1 cycle after `reg_rd_en`.
- `busy` out 1: high in every state except SYNC.
- `frame_err` out 1: one-cycle pulse on timeout, bad checksum or unknown command.

## Operation
- Frame format: SYNC 0xA5, CMD, ADDR, [DATA for write], CSUM.
  - CMD 0x01 is write (5-byte frame); CMD 0x02 is read (4-byte frame).
  - CSUM is CMD^ADDR^DATA for write and CMD^ADDR for read.
- Response bytes:
  - Write OK: 0x06.
  - Read OK: 0x06 followed by the read data byte.
  - Any error except timeout: 0x15 (NAK).
  - Timeout: no response.
- States: SYNC → CMD → ADDR → (DATA if write) → CSUM → EXEC → RESP0 → (RESP1 if read) → SYNC.
- SYNC: every byte other than 0xA5 is popped and discarded silently.
- CMD: any value other than 0x01/0x02 is latched as-is.
  - Parsing continues through a 4-byte frame length.
  - The frame is then NAKed with a `frame_err` pulse.
- EXEC, checksum good:
  - Write: `reg_wr_en` pulses with `reg_addr`/`reg_wr_data` stable.
  - Read: `reg_rd_en` pulses; `reg_rd_data` is captured on the following cycle.
- EXEC, checksum bad: `frame_err` pulses; no bus strobe; the response is 0x15.
- RX pop rule:
  - A byte is consumed only when `rx_available`=1 and the parser is in a receive state; `rx_data_ack` pulses that cycle.
  - After an ack in cycle t, `rx_data` must not be sampled before cycle t+2, because the uart's `rx_data` register lags its read pointer by one cycle.
- TX push rule:
  - `tx_data_valid` asserts only in a cycle where `tx_free`=1.
  - While `tx_free`=0 the parser holds in RESP0/RESP1 indefinitely; no byte is dropped.
- Timeout:
  - The counter clears on each consumed byte and counts only in CMD/ADDR/DATA/CSUM.
  - On reaching `TIMEOUT_CYCLES`: `frame_err` pulses and the state returns to SYNC.
  - No response is sent and no bus access occurs.
- Reset mid-frame: return to SYNC; counter and latched fields cleared. The uart FIFOs are not flushed.

## Timing
- Reset values: all outputs 0. State is SYNC; timeout counter and latched fields are 0.
- Byte consumption: at most one RX byte per 2 cycles (ack cycle plus one gap cycle).
- Latency from the CSUM byte ack to EXEC:
  - Write: `reg_wr_en` asserts 1 cycle after the CSUM ack.
  - Read: `reg_rd_en` asserts 1 cycle after the CSUM ack.
- First response push: 2 cycles after EXEC for write, 3 for read. This assumes `tx_free`=1.
- Between RESP0 and RESP1: one cycle minimum.
- Return to SYNC: on the cycle after the final push.
- Simultaneous `rx_available` and a response pending: responses are sent before any new byte is popped. No pipelining of frames.

## Structure
- Shared package `uart_cmd_pkg`:
  - constants SYNC_BYTE=0xA5, CMD_WRITE=0x01, CMD_READ=0x02, ACK_BYTE=0x06, NAK_BYTE=0x15;
  - state enum typedef.
- One sub-module, `uart_byte_reader`, owns the RX pop handshake and the t+2 gap. It presents a `byte_valid`/`byte` pulse to the parser FSM.
- The timeout counter and TX push logic are inline in the top module.

## Test plan
- Write command:
  - Stimulus: A5 01 10 3C 2D.
  - Required: one `reg_wr_en` pulse with `reg_addr`=0x10, `reg_wr_data`=0x3C; TX sends 0x06; `frame_err` stays 0.
- Read command:
  - Stimulus: A5 02 20 22, with `reg_rd_data`=0x5A.
  - Required: one `reg_rd_en` pulse with `reg_addr`=0x20; TX sends 0x06 then 0x5A.
- Bad checksum:
  - Stimulus: A5 01 10 3C 00.
  - Required: no `reg_wr_en`; one `frame_err` pulse; TX sends 0x15.
- Noise, then unknown command:
  - Stimulus: 00 FF 13 before A5 07 10 3C 2B.
  - Required: the leading bytes are popped silently; the frame yields `frame_err` plus 0x15; no bus strobe.
- Timeout:
  - Stimulus: A5 01 10, then silence for `TIMEOUT_CYCLES`+1 cycles.
  - Required: one `frame_err` pulse, no TX, and a subsequent valid write frame is accepted normally.
- Backpressure and reset:
  - Stimulus 1: hold `tx_free`=0 for 50 cycles during RESP0.
  - Required 1: no `tx_data_valid` until `tx_free` rises, then 0x06 is pushed exactly once.
  - Stimulus 2: assert `reset` during ADDR.
  - Required 2: all outputs 0 and state SYNC on the next cycle.
